sector_uart_dump: RTL and testbench

Controller that sequences one SD-card block read and streams the block out over the UART transmitter.
- A command byte received on the UART RX side triggers a read request to the SD reader.
- The block waits for the reader's data-ready flag, then fetches each of the 512 buffered bytes and feeds them to the UART TX handshake.
- An 8-bit checksum trailer follows the data. A response byte is sent instead on timeout.
- Sits between the SD card reader, its sector buffer and the UART top in the SD/UART test top level.

---
 rtl/sector_uart_dump_pkg.sv | 26 ++
 rtl/sector_uart_dump_tx_seq.sv | 47 ++++
 rtl/sector_uart_dump.sv | 113 +++++++++++
 tb/tb_sector_uart_dump.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sector_uart_dump_pkg.sv
// Shared definitions for the sector dump controller: FSM encodings and default constants.
package sector_uart_dump_pkg;

  localparam int          BLOCK_BYTES_DEF = 512;
  localparam logic [7:0]  CMD_BYTE_DEF    = 8'h52;
  localparam logic [7:0]  ERR_BYTE_DEF    = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RDY,
    ST_FETCH,
    ST_SEND,
    ST_WAIT_TX,
    ST_TRAIL,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_t;

endpackage

// File: rtl/sector_uart_dump_tx_seq.sv
// One-byte UART send handshake: strobe when idle, wait for busy high (2-cycle guard), then low.
module uart_tx_seq
  import sector_uart_dump_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_stb,
  output logic       done
);

  tx_state_t state, state_nxt;
  logic      guard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      guard   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state <= state_nxt;
      guard <= (state == TX_WAIT_HI);
      if (state == TX_IDLE && go) tx_data <= tx_byte;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:    if (go) state_nxt = TX_SEND;
      TX_SEND:    if (!tx_busy) state_nxt = TX_WAIT_HI;
      // A UART that never reports busy must not stall the dump.
      TX_WAIT_HI: if (tx_busy || guard) state_nxt = TX_WAIT_LO;
      TX_WAIT_LO: if (!tx_busy) state_nxt = TX_IDLE;
      default:    state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_stb = (state == TX_SEND) && !tx_busy;
    done   = (state == TX_WAIT_LO) && !tx_busy;
  end

endmodule

// File: rtl/sector_uart_dump.sv
// Sequences one SD block read on an 'R' command and streams the 512 bytes plus a checksum over UART.
module sector_uart_dump
  import sector_uart_dump_pkg::*;
#(
  parameter int         BLOCK_BYTES    = BLOCK_BYTES_DEF,
  parameter int         ADDR_W         = 9,
  parameter logic [7:0] CMD_BYTE       = CMD_BYTE_DEF,
  parameter logic [7:0] ERR_BYTE       = ERR_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rd_req,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic [7:0]        tx_data,
  output logic              tx_stb,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err_timeout
);

  localparam int                CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BLOCK_BYTES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       checksum;
  logic             data_phase;
  logic             go;
  logic [7:0]       go_byte;
  logic             done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (rx_valid && rx_data == CMD_BYTE) state_nxt = ST_REQ;
      ST_REQ:      state_nxt = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (rd_ready)                 state_nxt = ST_FETCH;
        else if (tmo_cnt == CNT_LAST) state_nxt = ST_ERR;
      end
      ST_FETCH:    state_nxt = ST_SEND;
      ST_SEND:     state_nxt = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (done) begin
          if (!data_phase)             state_nxt = ST_IDLE;
          else if (buf_addr == ADDR_LAST) state_nxt = ST_TRAIL;
          else                         state_nxt = ST_FETCH;
        end
      end
      ST_TRAIL:    state_nxt = ST_WAIT_TX;
      ST_ERR:      state_nxt = ST_WAIT_TX;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_req      = (state == ST_REQ) || (state == ST_WAIT_RDY);
    busy        = (state != ST_IDLE);
    err_timeout = (state == ST_ERR);
    go          = (state == ST_SEND) || (state == ST_TRAIL) || (state == ST_ERR);
    go_byte     = buf_data;
    if (state == ST_TRAIL) go_byte = checksum;
    if (state == ST_ERR)   go_byte = ERR_BYTE;
  end

  // ST_SEND is the cycle after the address was presented, so buf_data is valid here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt    <= '0;
      checksum   <= 8'h00;
      buf_addr   <= '0;
      data_phase <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          tmo_cnt    <= '0;
          checksum   <= 8'h00;
          buf_addr   <= '0;
          data_phase <= 1'b1;
        end
        ST_WAIT_RDY: tmo_cnt <= tmo_cnt + 1'b1;
        ST_SEND:     checksum <= checksum + buf_data;
        ST_WAIT_TX:  if (done && data_phase && buf_addr != ADDR_LAST) buf_addr <= buf_addr + 1'b1;
        ST_TRAIL,
        ST_ERR:      data_phase <= 1'b0;
        default: ;
      endcase
    end
  end

  uart_tx_seq u_tx_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .tx_byte (go_byte),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .tx_stb  (tx_stb),
    .done    (done)
  );

endmodule

// File: tb/tb_sector_uart_dump.sv
// Directed bench: SD reader, sector buffer and UART models around sector_uart_dump.
module tb_sector_uart_dump;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rd_req;
  logic       rd_ready = 1'b0;
  logic [8:0] buf_addr;
  logic [7:0] buf_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_busy;
  logic       busy;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [512];
  int  rdy_delay = 100;
  bit  sd_never  = 1'b0;
  int  busy_len  = 2;

  int  rdy_cnt  = 0;
  int  busy_cnt = 0;
  bit  stb_neg  = 1'b0;
  bit  req_neg  = 1'b0;

  int  cyc = 0, nstb = 0, sbb = 0, nreq = 0, nerr = 0, req_cyc = 0, err_cyc = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  sector_uart_dump #(.TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_req(rd_req), .rd_ready(rd_ready), .buf_addr(buf_addr), .buf_data(buf_data),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_busy(tx_busy), .busy(busy),
    .err_timeout(err_timeout)
  );

  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) buf_data <= mem[buf_addr];

  always @(posedge clk) begin
    if (!req_neg) begin
      rdy_cnt  <= 0;
      rd_ready <= 1'b0;
    end else if (!sd_never) begin
      if (rdy_cnt == rdy_delay) rd_ready <= 1'b1;
      else                      rdy_cnt  <= rdy_cnt + 1;
    end
    if (stb_neg && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0)       busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    stb_neg = tx_stb;
    if (rd_req && !req_neg) begin
      nreq = nreq + 1;
      req_cyc = cyc;
    end
    req_neg = rd_req;
    if (tx_stb) begin
      q.push_back(tx_data);
      nstb = nstb + 1;
      if (tx_busy) sbb = sbb + 1;
    end
    if (err_timeout) begin
      nerr = nerr + 1;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  function automatic int data_errs(input int base);
    int e = 0;
    if (q.size() < base + 513) return 9999;
    for (int i = 0; i < 512; i++) if (q[base + i] !== mem[i]) e++;
    return e;
  endfunction

  function automatic logic [7:0] trailer(input int base);
    if (q.size() < base + 513) return 8'hxx;
    return q[base + 512];
  endfunction

  task automatic dump_check(input string tag, input logic [7:0] exp_trail, input int budget);
    int b_q, b_stb, b_sbb, b_req;
    b_q = q.size(); b_stb = nstb; b_sbb = sbb; b_req = nreq;
    send_rx(8'h52);
    wait_idle(budget, {tag, "_idle"});
    check({tag, "_strobes"}, nstb - b_stb, 513);
    check({tag, "_stb_busy"}, sbb - b_sbb, 0);
    check({tag, "_reqs"}, nreq - b_req, 1);
    check({tag, "_data"}, data_errs(b_q), 0);
    check({tag, "_trailer"}, {24'd0, trailer(b_q)}, {24'd0, exp_trail});
  endtask

  initial begin
    int b_q, b_stb, b_req, b_err, n;

    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rd_req", {31'd0, rd_req}, 0);
    check("rst_tx_stb", {31'd0, tx_stb}, 0);
    check("rst_err", {31'd0, err_timeout}, 0);
    check("rst_addr", {23'd0, buf_addr}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: ramp pattern, trailer is 2*sum(0..255) mod 256 = 0
    dump_check("ramp", 8'h00, 20000);

    // 2: constant and single-byte buffers
    for (int i = 0; i < 512; i++) mem[i] = 8'h01;
    dump_check("ones", 8'h00, 20000);
    for (int i = 0; i < 512; i++) mem[i] = 8'h03;
    dump_check("threes", 8'h00, 20000);
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0] = 8'h05;
    dump_check("first5", 8'h05, 20000);

    // 3: reader never ready -> single error byte after 1000 cycles in WAIT_RDY
    sd_never = 1'b1;
    b_q = q.size(); b_stb = nstb; b_err = nerr;
    send_rx(8'h52);
    wait_idle(3000, "tmo_idle");
    check("tmo_strobes", nstb - b_stb, 1);
    check("tmo_pulses", nerr - b_err, 1);
    check("tmo_byte", (q.size() > b_q) ? {24'd0, q[b_q]} : 32'hffff, 32'h45);
    check("tmo_delay", err_cyc - req_cyc, 1001);
    sd_never = 1'b0;

    // 4: slow UART, then a UART that never reports busy
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    busy_len = 20;
    dump_check("slow", 8'h00, 30000);
    busy_len = 0;
    dump_check("nobusy", 8'h00, 20000);
    busy_len = 2;

    // 5: commands while busy are dropped; non-command in idle is ignored
    b_stb = nstb; b_req = nreq;
    send_rx(8'h52);
    repeat (300) @(negedge clk);
    send_rx(8'h52);
    send_rx(8'h41);
    wait_idle(20000, "mid_idle");
    check("mid_strobes", nstb - b_stb, 513);
    check("mid_reqs", nreq - b_req, 1);
    b_req = nreq;
    send_rx(8'h41);
    repeat (20) @(negedge clk);
    check("other_reqs", nreq - b_req, 0);
    check("other_busy", {31'd0, busy}, 0);

    // 6: reset in the middle of a dump, then a fresh dump
    b_stb = nstb;
    send_rx(8'h52);
    n = 0;
    while (nstb - b_stb < 200 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_count", (nstb - b_stb >= 200) ? 32'd1 : 32'd0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 0);
    check("ar_rd_req", {31'd0, rd_req}, 0);
    check("ar_tx_stb", {31'd0, tx_stb}, 0);
    check("ar_addr", {23'd0, buf_addr}, 0);
    check("ar_tx_data", {24'd0, tx_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    dump_check("fresh", 8'h00, 20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
